// File: rtl/pipelined_adder_n.sv
// Pipelined WIDTH-bit adder/subtractor: one CHUNK-wide ripple slice per stage, NSTG cycles latency.
// Whole pipeline advances only when the output slot is empty or being drained (in_ready = adv).
module pipelined_adder_n #(
  parameter int WIDTH = 128,
  parameter int CHUNK = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int NSTG = WIDTH / CHUNK;

  logic             vld_q [NSTG];
  logic [WIDTH-1:0] a_q   [NSTG];
  logic [WIDTH-1:0] b_q   [NSTG];
  logic [WIDTH-1:0] s_q   [NSTG];
  logic             c_q   [NSTG];
  logic             ovf_q;

  logic             v_src [NSTG];
  logic [WIDTH-1:0] a_src [NSTG];
  logic [WIDTH-1:0] b_src [NSTG];
  logic [WIDTH-1:0] s_src [NSTG];
  logic             c_src [NSTG];
  logic [WIDTH-1:0] s_nx  [NSTG];
  logic             c_nx  [NSTG];
  logic [CHUNK:0]   part  [NSTG];
  logic             ovf_nx;
  logic             adv;

  assign adv      = !vld_q[NSTG-1] || out_ready;
  assign in_ready = adv;

  always_comb begin
    // Stage 0 sees the ports; subtraction is folded in as A + ~B + 1.
    v_src[0] = in_valid;
    a_src[0] = a;
    b_src[0] = sub ? ~b : b;
    c_src[0] = sub | cin;
    s_src[0] = '0;
    for (int k = 1; k < NSTG; k++) begin
      v_src[k] = vld_q[k-1];
      a_src[k] = a_q[k-1];
      b_src[k] = b_q[k-1];
      s_src[k] = s_q[k-1];
      c_src[k] = c_q[k-1];
    end
    for (int k = 0; k < NSTG; k++) begin
      part[k] = {1'b0, a_src[k][k*CHUNK +: CHUNK]}
              + {1'b0, b_src[k][k*CHUNK +: CHUNK]}
              + {{CHUNK{1'b0}}, c_src[k]};
      s_nx[k] = s_src[k];
      s_nx[k][k*CHUNK +: CHUNK] = part[k][CHUNK-1:0];
      c_nx[k] = part[k][CHUNK];
    end
    // Equivalent to carry-into-MSB XOR carry-out-of-MSB.
    ovf_nx = (a_src[NSTG-1][WIDTH-1] == b_src[NSTG-1][WIDTH-1]) &&
             (s_nx[NSTG-1][WIDTH-1] != a_src[NSTG-1][WIDTH-1]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NSTG; k++) begin
        vld_q[k] <= 1'b0;
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        s_q[k]   <= '0;
        c_q[k]   <= 1'b0;
      end
      ovf_q <= 1'b0;
    end else if (adv) begin
      for (int k = 0; k < NSTG; k++) begin
        vld_q[k] <= v_src[k];
        a_q[k]   <= a_src[k];
        b_q[k]   <= b_src[k];
        s_q[k]   <= s_nx[k];
        c_q[k]   <= c_nx[k];
      end
      ovf_q <= ovf_nx;
    end
  end

  assign out_valid = vld_q[NSTG-1];
  assign sum       = s_q[NSTG-1];
  assign cout      = c_q[NSTG-1];
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_adder_n.sv
// Bench for pipelined_adder_n: directed arithmetic, back-pressure, async reset, and NSTG=1/16 sweeps.
module tb_pipelined_adder_n;
  localparam int W = 128;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;

  logic         in_ready0, in_ready1, in_ready2;
  logic         out_valid0, out_valid1, out_valid2;
  logic         cout0, cout1, cout2, ovf0, ovf1, ovf2;
  logic [W-1:0] sum0, sum1, sum2;

  always #5 clk = ~clk;

  pipelined_adder_n #(.WIDTH(W), .CHUNK(32)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0), .a(a), .b(b),
    .cin(cin), .sub(sub), .out_valid(out_valid0), .out_ready(out_ready), .sum(sum0),
    .cout(cout0), .ovf(ovf0));
  pipelined_adder_n #(.WIDTH(W), .CHUNK(128)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1), .a(a), .b(b),
    .cin(cin), .sub(sub), .out_valid(out_valid1), .out_ready(out_ready), .sum(sum1),
    .cout(cout1), .ovf(ovf1));
  pipelined_adder_n #(.WIDTH(W), .CHUNK(8)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2), .a(a), .b(b),
    .cin(cin), .sub(sub), .out_valid(out_valid2), .out_ready(out_ready), .sum(sum2),
    .cout(cout2), .ovf(ovf2));

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    int           t;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  logic         prev_stall = 1'b0;
  logic [W-1:0] prev_sum = '0;
  logic         prev_cout = 1'b0;
  logic         prev_ovf = 1'b0;
  logic         last_in_ready = 1'b0;

  always @(posedge clk) cyc++;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: signed/unsigned arithmetic on widened integers.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic ci, input logic s, input int t);
    exp_t e;
    logic signed [W+1:0] sx, sy, r;
    logic [W:0] u;
    sx = $signed({x[W-1], x[W-1], x});
    sy = $signed({y[W-1], y[W-1], y});
    if (s) begin
      r = sx - sy;
      e.cout = (x >= y);
    end else begin
      r = sx + sy + $signed({{(W+1){1'b0}}, ci});
      u = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
      e.cout = u[W];
    end
    e.sum = r[W-1:0];
    e.ovf = (r[W+1:W-1] != 3'b000) && (r[W+1:W-1] != 3'b111);
    e.t = t;
    return e;
  endfunction

  function automatic logic [W-1:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic observe0();
    if (prev_stall) begin
      chk("stall_hold_valid", out_valid0, 1);
      chk("stall_hold_sum", sum0, prev_sum);
      chk("stall_hold_cout", cout0, prev_cout);
      chk("stall_hold_ovf", ovf0, prev_ovf);
    end
    if (out_valid0) begin
      if (q0.size() == 0) chk("unexpected_out_valid", out_valid0, 0);
      else begin
        chk("sum", sum0, q0[0].sum);
        chk("cout", cout0, q0[0].cout);
        chk("ovf", ovf0, q0[0].ovf);
      end
    end
  endtask

  // Drive at the falling edge, let one rising edge happen, then check.
  task automatic cycle0(input logic iv, input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input logic ic, input logic is, input logic ordy, output logic acc);
    in_valid = iv; a = ia; b = ib; cin = ic; sub = is; out_ready = ordy;
    #1;
    last_in_ready = in_ready0;
    chk("in_ready_rule", in_ready0, !out_valid0 || ordy);
    acc = iv && in_ready0;
    if (acc) q0.push_back(model(ia, ib, ic, is, cyc + 1));
    if (out_valid0 && ordy && q0.size() > 0) void'(q0.pop_front());
    prev_stall = out_valid0 && !ordy;
    prev_sum = sum0; prev_cout = cout0; prev_ovf = ovf0;
    @(posedge clk);
    @(negedge clk);
    observe0();
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) cycle0(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc);
  endtask

  task automatic directed(input string tag, input logic [W-1:0] da, input logic [W-1:0] db,
                          input logic dc, input logic ds, input logic [W-1:0] es,
                          input logic ec, input logic eo);
    logic acc;
    int t;
    cycle0(1'b1, da, db, dc, ds, 1'b1, acc);
    t = cyc;
    chk({tag, "_accept"}, acc, 1);
    for (int i = 0; i < 10 && !out_valid0; i++) idle(1);
    chk({tag, "_valid"}, out_valid0, 1);
    chk({tag, "_latency"}, cyc - t, 3);
    chk({tag, "_sum"}, sum0, es);
    chk({tag, "_cout"}, cout0, ec);
    chk({tag, "_ovf"}, ovf0, eo);
    idle(1);
  endtask

  task automatic sweep_step(input logic iv, input logic [W-1:0] ia, input logic [W-1:0] ib,
                            input logic ic, input logic is);
    logic ev;
    in_valid = iv; a = ia; b = ib; cin = ic; sub = is; out_ready = 1'b1;
    #1;
    chk("n1_in_ready", in_ready1, 1);
    chk("n16_in_ready", in_ready2, 1);
    if (iv) begin
      q1.push_back(model(ia, ib, ic, is, cyc + 1));
      q2.push_back(model(ia, ib, ic, is, cyc + 1));
    end
    @(posedge clk);
    @(negedge clk);
    ev = (q1.size() > 0) && (cyc - q1[0].t == 0);
    chk("n1_valid_latency", out_valid1, ev);
    if (out_valid1 && ev) begin
      chk("n1_sum", sum1, q1[0].sum);
      chk("n1_cout", cout1, q1[0].cout);
      chk("n1_ovf", ovf1, q1[0].ovf);
      void'(q1.pop_front());
    end
    ev = (q2.size() > 0) && (cyc - q2[0].t == 15);
    chk("n16_valid_latency", out_valid2, ev);
    if (out_valid2 && ev) begin
      chk("n16_sum", sum2, q2[0].sum);
      chk("n16_cout", cout2, q2[0].cout);
      chk("n16_ovf", ovf2, q2[0].ovf);
      void'(q2.pop_front());
    end
  endtask

  initial begin
    logic acc;
    logic stall;
    logic [W-1:0] all1, msb, maxpos;
    int sent, t0, n;
    exp_t e;
    logic [W-1:0] ra, rb;
    logic rc, rs;

    all1 = '1;
    msb = {1'b1, {(W-1){1'b0}}};
    maxpos = {1'b0, {(W-1){1'b1}}};

    // Reset values while rst_n is low.
    #2;
    chk("rst_out_valid", out_valid0, 0);
    chk("rst_sum", sum0, 0);
    chk("rst_cout", cout0, 0);
    chk("rst_ovf", ovf0, 0);
    chk("rst_in_ready", in_ready0, 1);
    @(negedge clk);
    rst_n = 1'b1;

    // Single beat: valid exactly 4 edges after acceptance, then gone.
    cycle0(1'b1, 1, 1, 1'b0, 1'b0, 1'b1, acc);
    t0 = cyc;
    chk("t1_accept", acc, 1);
    for (int i = 0; i < 5; i++) begin
      chk("t1_valid", out_valid0, (cyc - t0) == 3);
      if (out_valid0) begin
        chk("t1_sum", sum0, 2);
        chk("t1_cout", cout0, 0);
        chk("t1_ovf", ovf0, 0);
      end
      if (i < 4) idle(1);
    end

    directed("ripple", all1, 0, 1'b1, 1'b0, 0, 1'b1, 1'b0);
    directed("posovf", maxpos, 1, 1'b0, 1'b0, msb, 1'b0, 1'b1);
    directed("sub5m7", 5, 7, 1'b1, 1'b1, all1 - 1, 1'b0, 1'b0);
    directed("subneg", msb, 1, 1'b0, 1'b1, maxpos, 1'b1, 1'b1);

    // Back-pressure: 10 ops back-to-back, 3-cycle stall once op #2 is presented.
    sent = 0;
    t0 = -1;
    for (int i = 0; i < 40 && (sent < 10 || q0.size() > 0); i++) begin
      stall = (t0 >= 0) && (cyc >= t0 + 4) && (cyc <= t0 + 6);
      cycle0(sent < 10, rnd128(), rnd128(), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), !stall, acc);
      chk("bp_in_ready", last_in_ready, !stall);
      if (acc) begin
        if (sent == 0) t0 = cyc;
        sent++;
      end
    end
    chk("bp_sent", sent, 10);
    chk("bp_drained", q0.size(), 0);

    // Random valid/ready toggling.
    sent = 0;
    n = 0;
    while (sent < 10000 && n < 40000) begin
      ra = rnd128();
      rb = rnd128();
      if ($urandom_range(0, 15) == 0) ra = all1;
      if ($urandom_range(0, 15) == 0) rb = msb;
      cycle0($urandom_range(0, 3) != 0, ra, rb, 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0, acc);
      if (acc) sent++;
      n++;
    end
    for (int i = 0; i < 20 && q0.size() > 0; i++) idle(1);
    chk("rand_sent", sent, 10000);
    chk("rand_drained", q0.size(), 0);

    // Asynchronous reset with a result presented and 3 more in flight.
    for (int i = 0; i < 4; i++) cycle0(1'b1, rnd128(), rnd128(), 1'b0, 1'b0, 1'b1, acc);
    chk("ar_valid_before", out_valid0, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_out_valid", out_valid0, 0);
    chk("ar_in_ready", in_ready0, 1);
    chk("ar_sum", sum0, 0);
    q0.delete();
    prev_stall = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      idle(1);
      chk("ar_no_stale", out_valid0, 0);
    end
    ra = rnd128();
    rb = rnd128();
    e = model(ra, rb, 1'b1, 1'b0, 0);
    directed("ar_next", ra, rb, 1'b1, 1'b0, e.sum, e.cout, e.ovf);

    // Parameter sweep on NSTG=1 and NSTG=16 instances.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    q1.delete();
    q2.delete();
    sent = 0;
    for (int i = 0; i < 3000 && sent < 1000; i++) begin
      ra = rnd128();
      rb = rnd128();
      rc = 1'($urandom_range(0, 1));
      rs = 1'($urandom_range(0, 1));
      acc = $urandom_range(0, 3) != 0;
      sweep_step(acc, ra, rb, rc, rs);
      if (acc) sent++;
    end
    for (int i = 0; i < 20; i++) sweep_step(1'b0, '0, '0, 1'b0, 1'b0);
    chk("sweep_sent", sent, 1000);
    chk("n1_drained", q1.size(), 0);
    chk("n16_drained", q2.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
